// File: rtl/mc_bank_seq.sv
// SDRAM bank command sequencer: issues PRE/ACT/RD/WR and PREA/REF with tRP/tRCD/tRFC spacing.
// Define MC_BANK_SEQ_AUTO_PRE_EN for closed-page policy (auto-precharge on every RD/WR).
module mc_bank_seq #(
    parameter int unsigned TRP  = 3,
    parameter int unsigned TRCD = 3,
    parameter int unsigned TRFC = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [12:0] req_row,
    input  logic [1:0]  req_bank,
    input  logic        ref_req,
    output logic        ref_ack,
    output logic [12:0] row_adr,
    output logic [1:0]  bank_adr,
    output logic        bank_set,
    output logic        bank_clr,
    output logic        bank_clr_all,
    input  logic        bank_open,
    input  logic        any_bank_open,
    input  logic        row_same,
    output logic [2:0]  cmd,
    output logic        cmd_ap
);

    typedef enum logic [3:0] {
        IDLE, CHECK, WAIT_RP, ACT, WAIT_RCD, COL, PREA, WAIT_RPA, REF, WAIT_RFC
    } state_t;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_PRE  = 3'd1,
        CMD_PREA = 3'd2,
        CMD_ACT  = 3'd3,
        CMD_RD   = 3'd4,
        CMD_WR   = 3'd5,
        CMD_REF  = 3'd6
    } cmd_t;

`ifdef MC_BANK_SEQ_AUTO_PRE_EN
    localparam logic AUTO_PRE = 1'b1;
`else
    localparam logic AUTO_PRE = 1'b0;
`endif

    // Counter preloads N-2 so the next command lands exactly N cycles after the issuing one.
    localparam logic [3:0] RP_LOAD  = 4'(TRP - 2);
    localparam logic [3:0] RCD_LOAD = 4'(TRCD - 2);
    localparam logic [3:0] RFC_LOAD = 4'(TRFC - 2);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       we;
    logic       latch;
    logic       col_issue;
    logic       rp_idle, rp_idle_nxt;
    cmd_t       cmd_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            row_adr  <= '0;
            bank_adr <= '0;
            we       <= 1'b0;
            rp_idle  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rp_idle <= rp_idle_nxt;
            if (latch) begin
                row_adr  <= req_row;
                bank_adr <= req_bank;
                we       <= req_we;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rp_idle_nxt  = rp_idle;
        latch        = 1'b0;
        col_issue    = 1'b0;
        cmd_c        = CMD_NOP;
        bank_set     = 1'b0;
        bank_clr     = 1'b0;
        bank_clr_all = 1'b0;
        ref_ack      = 1'b0;
        req_ready    = 1'b0;

        case (state)
            IDLE: begin
                req_ready = !ref_req;
                if (ref_req) begin
                    state_nxt = any_bank_open ? PREA : REF;
                end else if (req_valid) begin
                    latch     = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (bank_open && row_same) begin
                    col_issue = 1'b1;
                end else if (!bank_open) begin
                    cmd_c     = CMD_ACT;
                    bank_set  = 1'b1;
                    cnt_nxt   = RCD_LOAD;
                    state_nxt = WAIT_RCD;
                end else begin
                    cmd_c       = CMD_PRE;
                    bank_clr    = 1'b1;
                    cnt_nxt     = RP_LOAD;
                    rp_idle_nxt = 1'b0;
                    state_nxt   = WAIT_RP;
                end
            end
            WAIT_RP: begin
                if (cnt == '0) state_nxt = rp_idle ? IDLE : ACT;
                else           cnt_nxt   = cnt - 4'd1;
            end
            ACT: begin
                cmd_c     = CMD_ACT;
                bank_set  = 1'b1;
                cnt_nxt   = RCD_LOAD;
                state_nxt = WAIT_RCD;
            end
            WAIT_RCD: begin
                if (cnt == '0) state_nxt = COL;
                else           cnt_nxt   = cnt - 4'd1;
            end
            COL: col_issue = 1'b1;
            PREA: begin
                cmd_c        = CMD_PREA;
                bank_clr_all = 1'b1;
                cnt_nxt      = RP_LOAD;
                state_nxt    = WAIT_RPA;
            end
            WAIT_RPA: begin
                if (cnt == '0) state_nxt = REF;
                else           cnt_nxt   = cnt - 4'd1;
            end
            REF: begin
                cmd_c     = CMD_REF;
                cnt_nxt   = RFC_LOAD;
                state_nxt = WAIT_RFC;
            end
            WAIT_RFC: begin
                if (cnt == '0) begin
                    ref_ack   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Shared column issue for CHECK hits and COL; closed-page reuses WAIT_RP with a return-to-IDLE flag.
        if (col_issue) begin
            cmd_c = we ? CMD_WR : CMD_RD;
            if (AUTO_PRE) begin
                bank_clr    = 1'b1;
                cnt_nxt     = RP_LOAD;
                rp_idle_nxt = 1'b1;
                state_nxt   = WAIT_RP;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    assign cmd    = cmd_c;
    assign cmd_ap = AUTO_PRE & col_issue;

endmodule

// File: doc/mc_bank_seq.md
Name: mc_bank_seq

Overview:
Per-chip-select SDRAM bank command sequencer that sits directly upstream of the open-bank/row tracker and consumes its results. It accepts one access request at a time (bank, row, read/write) and presents the latched bank/row to the tracker. Using the tracker's bank_open/row_same/any_bank_open results, it issues PRE/ACT/RD/WR or PREA/REF commands with tRP/tRCD/tRFC spacing. It drives bank_set/bank_clr/bank_clr_all back into the tracker.

Parameters:
TRP, 3, precharge-to-activate spacing in clk cycles (legal range 2..15)
TRCD, 3, activate-to-column-command spacing in clk cycles (legal range 2..15)
TRFC, 7, refresh-to-next-command spacing in clk cycles (legal range 2..15)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  access request present
req_ready  out  1  request accepted when req_valid & req_ready
req_we  in  1  1=write, 0=read
req_row  in  13  row address
req_bank  in  2  bank address
ref_req  in  1  refresh request, level, held until ref_ack
ref_ack  out  1  one-cycle pulse, refresh complete
row_adr  out  13  latched row, to tracker
bank_adr  out  2  latched bank, to tracker
bank_set  out  1  to tracker, asserted on ACT cycle
bank_clr  out  1  to tracker, asserted on PRE cycle
bank_clr_all  out  1  to tracker, asserted on PREA cycle
bank_open  in  1  from tracker
any_bank_open  in  1  from tracker
row_same  in  1  from tracker
cmd  out  3  0 NOP, 1 PRE, 2 PREA, 3 ACT, 4 RD, 5 WR, 6 REF
cmd_ap  out  1  auto-precharge flag qualifying RD/WR

Behaviour:
- Reset: state IDLE; counter 0; row_adr 0; bank_adr 0; cmd NOP; all strobes, ref_ack, cmd_ap 0. req_ready is 1 after reset if ref_req=0.
- States: IDLE, CHECK, WAIT_RP, ACT, WAIT_RCD, COL, PREA, WAIT_RPA, REF, WAIT_RFC.
- IDLE: req_ready = !ref_req.
  - ref_req=1: go to PREA if any_bank_open, else go to REF. Refresh beats a simultaneous req_valid.
  - Otherwise, on req_valid: latch req_row/req_bank/req_we into row_adr/bank_adr/we, then go to CHECK.
- CHECK: tracker outputs reflect the latched address. The command is decoded combinationally in this cycle:
  - bank_open & row_same (hit): cmd RD/WR, go to IDLE.
  - !bank_open (closed): cmd ACT, bank_set=1, go to WAIT_RCD.
  - bank_open & !row_same (conflict): cmd PRE, bank_clr=1, go to WAIT_RP.
- Spacing rule: a command issued at cycle t with spacing N puts the next command at exactly cycle t+N.
  - The counter loads N-2 on issue; the wait state exits when the counter reaches 0.
- WAIT_RP → ACT (cmd ACT, bank_set=1) → WAIT_RCD → COL (cmd RD/WR, one cycle) → IDLE.
- PREA: cmd PREA, bank_clr_all=1 → WAIT_RPA (TRP) → REF.
- REF: cmd REF → WAIT_RFC (TRFC). On the final WAIT_RFC cycle, ref_ack=1, then go to IDLE.
- cmd is NOP in every wait state. Each strobe is asserted for exactly one cycle, coincident with its command.
- Latched row_adr/bank_adr are stable from CHECK until the return to IDLE.
- Latencies with defaults (accept at cycle 0):
  - hit: RD/WR at cycle 1
  - closed: ACT at 1, RD/WR at 4
  - conflict: PRE at 1, ACT at 4, RD/WR at 7
- Reset mid-operation: immediately returns to IDLE and drops all outputs to reset values. The tracker shares rst, so all banks read closed.
- Counter width is 4 bits; parameters outside 2..15 are illegal.

Optional Feature:
MC_BANK_SEQ_AUTO_PRE_EN
- With the macro defined (closed-page policy):
  - Every RD/WR asserts cmd_ap=1 and bank_clr=1 in the same cycle.
  - The FSM then passes through WAIT_RP (TRP, entered directly from COL/CHECK) before IDLE, so the next ACT on any bank respects tRP.
  - Hits still occur only if the tracker reports the bank open, which does not happen in steady state.
- Without the macro (open-page policy): cmd_ap is tied to 0, the bank stays open after RD/WR, and the FSM returns straight to IDLE.

Test Plan:
1. After reset, req bank=1 row=0x0123 read accepted at cycle 0 → ACT + bank_set at 1, RD at 4, req_ready high again at 5.
2. Repeat bank=1 row=0x0123 write → WR at the CHECK cycle (1), no ACT/PRE, no strobes.
3. bank=1 row=0x0456 read → PRE + bank_clr at 1, ACT + bank_set at 4, RD at 7, row_adr=0x0456 throughout.
4. Bank 1 open; ref_req=1 and req_valid=1 together in IDLE → req_ready=0, PREA + bank_clr_all at 1, REF at 4, ref_ack pulse at 10, any_bank_open=0, then the request is accepted.
5. rst asserted during WAIT_RCD → same-cycle cmd NOP, state IDLE, strobes 0; after release the same request takes the closed path (ACT).
6. With MC_BANK_SEQ_AUTO_PRE_EN: two reads to bank 0 row 0x0010 → each ACT/RD with cmd_ap=1 + bank_clr on RD. The second request goes through ACT again, which comes ≥3 cycles after the first RD.
